// File: rtl/complex_mult_pkg.sv
// Shared definitions for the sequential complex multiplier: state encoding,
// product issue order and default operand width.
package complex_mult_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Product issue order through the shared multiplier
    localparam logic [1:0] P_RR = 2'd0;  // a_re*b_re
    localparam logic [1:0] P_II = 2'd1;  // a_im*b_im
    localparam logic [1:0] P_RI = 2'd2;  // a_re*b_im
    localparam logic [1:0] P_IR = 2'd3;  // a_im*b_re

    // Four products at two cycles each, plus one cycle to fold in the last
    localparam logic [3:0] MUL_LAST = 4'd8;

endpackage

// File: rtl/mult_8bit_sign.sv
// Two-stage pipelined signed multiplier: operands registered, then product
// registered, so a result appears two edges after its operands are presented.
module mult_8bit_sign
    import complex_mult_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    logic signed [W-1:0]   a_q;
    logic signed [W-1:0]   b_q;
    logic signed [2*W-1:0] p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
            p_q <= (2*W)'(a_q) * (2*W)'(b_q);
        end
    end

    assign p = p_q;

endmodule

// File: rtl/complex_mult_seq.sv
// Sequential complex multiplier y = a*b, time-sharing one pipelined multiplier
// across four partial products with a fixed accept-to-result latency of 9.
//
//   state | meaning
//   IDLE  | waiting for an operand set, in_ready=1
//   MUL   | issuing four products, accumulating into acc_re/acc_im
//   DONE  | result held on y_re/y_im until out_ready
module complex_mult_seq
    import complex_mult_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [2*W:0] y_re,
    output logic signed [2*W:0] y_im
);

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic signed [W-1:0]   op_ar, op_ai, op_br, op_bi;
    logic signed [W-1:0]   mul_a, mul_b;
    logic signed [2*W-1:0] prod;
    logic signed [2*W:0]   pext;
    logic signed [2*W:0]   acc_re, acc_im;
    logic [1:0]            iss_idx, acc_idx;
    logic                  accept, acc_en;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign y_re      = acc_re;
    assign y_im      = acc_im;

    // Product k is issued at cnt=2k and emerges from the pipeline at cnt=2k+2
    assign iss_idx = cnt[2:1];
    assign acc_idx = cnt[2:1] - 2'd1;
    assign acc_en  = (state == MUL) && (cnt != 4'd0) && !cnt[0];
    assign pext    = {prod[2*W-1], prod};

    always_comb begin
        mul_a = op_ar;
        mul_b = op_br;
        case (iss_idx)
            P_RR: begin mul_a = op_ar; mul_b = op_br; end
            P_II: begin mul_a = op_ai; mul_b = op_bi; end
            P_RI: begin mul_a = op_ar; mul_b = op_bi; end
            P_IR: begin mul_a = op_ai; mul_b = op_br; end
            default: ;
        endcase
    end

    mult_8bit_sign #(.W(W)) u_mult (
        .clk (clk),
        .rst (rst),
        .a   (mul_a),
        .b   (mul_b),
        .p   (prod)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     if (cnt == MUL_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_re <= '0;
            acc_im <= '0;
            op_ar  <= '0;
            op_ai  <= '0;
            op_br  <= '0;
            op_bi  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_ar  <= a_re;
                op_ai  <= a_im;
                op_br  <= b_re;
                op_bi  <= b_im;
                cnt    <= '0;
                acc_re <= '0;
                acc_im <= '0;
            end else if (state == MUL) begin
                cnt <= cnt + 4'd1;
                if (acc_en) begin
                    case (acc_idx)
                        P_RR:    acc_re <= acc_re + pext;
                        P_II:    acc_re <= acc_re - pext;
                        P_RI:    acc_im <= acc_im + pext;
                        P_IR:    acc_im <= acc_im + pext;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_mult_seq.sv
// Directed bench for complex_mult_seq: hand-computed products, stall,
// mid-computation reset and back-to-back ordering.
module tb_complex_mult_seq;

    localparam int W = 8;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] a_re, a_im, b_re, b_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [2*W:0] y_re, y_im;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    complex_mult_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_re      (y_re),
        .y_im      (y_im)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int ar, input int ai, input int br, input int bi);
        a_re     = 8'(ar);
        a_im     = 8'(ai);
        b_re     = 8'(br);
        b_im     = 8'(bi);
        in_valid = 1'b1;
    endtask

    // Waits for out_valid after an accept edge; lat=99 on timeout
    task automatic wait_out(output int lat);
        lat = 99;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_one(input string tag, input int ar, input int ai,
                           input int br, input int bi,
                           input int exp_re, input int exp_im);
        int lat;
        drive(ar, ai, br, bi);
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, in_ready, 0);
        wait_out(lat);
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_re"}, y_re, exp_re);
        chk({tag, "_im"}, y_im, exp_im);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_clr"}, out_valid, 0);
        chk({tag, "_rdy_back"}, in_ready, 1);
    endtask

    int lat_v;
    int seen;
    int b2b_re [4] = '{-5, -35, 16130, 1};
    int b2b_im [4] = '{10, 10, 0, -5};
    int b2b_op [4][4] = '{'{1, 2, 3, 4}, '{-5, 0, 7, -2},
                          '{127, -1, 127, 1}, '{-1, -1, 2, 3}};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", dut.state, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_yre", y_re, 0);
        chk("rst_yim", y_im, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_rdy", in_ready, 1);

        run_one("v1", 10, 4, -3, -7, -2, -82);
        run_one("v2", -3, 12, 5, -3, 21, 69);
        run_one("v3", -128, -128, -128, -128, 0, 32768);

        // Stall: result held, next set waits with in_valid asserted throughout
        drive(6, -2, 3, 5);
        tick();
        drive(-4, 9, 2, -1);
        wait_out(lat_v);
        chk("stall_lat", lat_v, 9);
        for (int k = 0; k < 20; k++) begin
            chk("stall_vld", out_valid, 1);
            chk("stall_re", y_re, 28);
            chk("stall_im", y_im, 24);
            chk("stall_rdy", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_rel_vld", out_valid, 0);
        chk("stall_rel_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("stall_next_acc", in_ready, 0);
        wait_out(lat_v);
        chk("stall_next_lat", lat_v, 9);
        chk("stall_next_re", y_re, 1);
        chk("stall_next_im", y_im, 22);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in cycle 4 of MUL discards the computation
        drive(20, 30, 40, 50);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_rdy", in_ready, 0);
        chk("mid_rst_yre", y_re, 0);
        chk("mid_rst_yim", y_im, 0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid_rst_no_out", seen, 0);
        run_one("v4", 1, 1, 1, -1, 2, 0);

        // Back-to-back with out_ready held high
        begin
            int in_n = 0;
            int out_n = 0;
            int last = 0;
            bit acc_now, hs_now;
            out_ready = 1'b1;
            drive(b2b_op[0][0], b2b_op[0][1], b2b_op[0][2], b2b_op[0][3]);
            for (int k = 0; k < 100 && out_n < 4; k++) begin
                acc_now = in_valid && in_ready;
                hs_now  = out_valid && out_ready;
                if (hs_now) begin
                    chk("b2b_re", y_re, b2b_re[out_n]);
                    chk("b2b_im", y_im, b2b_im[out_n]);
                    // 9 cycles to result, 1 in DONE, 1 in IDLE before next accept
                    if (out_n > 0) chk("b2b_gap", cyc - last, 11);
                    last = cyc;
                    out_n++;
                end
                tick();
                if (acc_now) begin
                    in_n++;
                    if (in_n < 4)
                        drive(b2b_op[in_n][0], b2b_op[in_n][1],
                              b2b_op[in_n][2], b2b_op[in_n][3]);
                    else
                        in_valid = 1'b0;
                end
            end
            chk("b2b_count", out_n, 4);
            out_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
